// File: rtl/serial_frame_sequencer_if.sv
// Handshake and bit-mux bundle for serial_frame_sequencer.
// master = sequencer side, slave = frame source / sink / mux side.
interface serial_frame_sequencer_if;
  logic         load_valid;
  logic         load_ready;
  logic [127:0] load_data;
  logic [127:0] mux_frame;
  logic [6:0]   mux_select;
  logic         mux_bit;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_data;
  logic         ser_last;
  logic         busy;

  modport master (
    input  load_valid, load_data, mux_bit, ser_ready,
    output load_ready, mux_frame, mux_select,
    output ser_valid, ser_data, ser_last, busy
  );

  modport slave (
    output load_valid, load_data, mux_bit, ser_ready,
    input  load_ready, mux_frame, mux_select,
    input  ser_valid, ser_data, ser_last, busy
  );
endinterface

// File: rtl/serial_frame_sequencer.sv
// Serialises a latched frame through an external 128:1 bit mux,
// one bit per accepted handshake, with last-bit marking.
module serial_frame_sequencer #(
  parameter int LEN       = 128,
  parameter int MSB_FIRST = 0
) (
  input logic                       clock,
  input logic                       reset,
  serial_frame_sequencer_if.master  sif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [6:0] LAST_IDX = 7'(LEN - 1);
  localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

  state_t       state;
  logic [127:0] frame;
  logic [6:0]   index;
  logic [7:0]   count;
  logic         sv;
  logic         sd;
  logic         sl;

  assign sif.mux_frame  = frame;
  assign sif.mux_select = (state == IDLE) ? 7'd0 : index;
  assign sif.load_ready = reset && (state == IDLE);
  assign sif.busy       = (state != IDLE);
  assign sif.ser_valid  = sv;
  assign sif.ser_data   = sd;
  assign sif.ser_last   = sl;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      frame <= '0;
      index <= '0;
      count <= '0;
      sv    <= 1'b0;
      sd    <= 1'b0;
      sl    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sif.load_valid) begin
            frame <= sif.load_data;
            index <= (MSB_FIRST != 0) ? LAST_IDX : 7'd0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (!sv || sif.ser_ready) begin
            sd    <= sif.mux_bit;
            sv    <= 1'b1;
            sl    <= (count == LAST_CNT);
            count <= count + 8'd1;
            // index parks on the final bit so it never leaves 0..LEN-1
            if (count == LAST_CNT) begin
              state <= DRAIN;
            end else if (MSB_FIRST != 0) begin
              index <= index - 7'd1;
            end else begin
              index <= index + 7'd1;
            end
          end
        end
        DRAIN: begin
          if (sif.ser_ready) begin
            sv    <= 1'b0;
            sl    <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Bench for serial_frame_sequencer: three variants (LSB-first, MSB-first,
// LEN=1) checked against a frame-order reference model.
module tb_serial_frame_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [2:0]   lv = '0;
  logic [2:0]   rdy = '0;
  logic [127:0] ld [3];
  logic [2:0]   sv_w, sd_w, sl_w, lr_w, bz_w;
  logic [6:0]   sel_w [3];
  logic [127:0] mf_w [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_frame_sequencer_if sif [3] ();

  for (genvar g = 0; g < 3; g++) begin : gd
    serial_frame_sequencer #(
      .LEN       (g == 2 ? 1 : 128),
      .MSB_FIRST (g == 1 ? 1 : 0)
    ) dut (
      .clock (clk),
      .reset (reset),
      .sif   (sif[g].master)
    );
    assign sif[g].load_valid = lv[g];
    assign sif[g].load_data  = ld[g];
    assign sif[g].ser_ready  = rdy[g];
    assign sif[g].mux_bit    = sif[g].mux_frame[sif[g].mux_select];
    assign sv_w[g]  = sif[g].ser_valid;
    assign sd_w[g]  = sif[g].ser_data;
    assign sl_w[g]  = sif[g].ser_last;
    assign lr_w[g]  = sif[g].load_ready;
    assign bz_w[g]  = sif[g].busy;
    assign sel_w[g] = sif[g].mux_select;
    assign mf_w[g]  = sif[g].mux_frame;
  end

  function automatic int len_of(input int d);
    return (d == 2) ? 1 : 128;
  endfunction

  function automatic bit msb_of(input int d);
    return d == 1;
  endfunction

  // Position in the frame of the k-th emitted bit
  function automatic int ord(input int d, input int k);
    return msb_of(d) ? len_of(d) - 1 - k : k;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller sits just after a negedge with the DUT idle.
  task automatic do_frame(input int d, input logic [127:0] f,
                          input int mode, input bit glitch,
                          input int abort_at,
                          output int cyc, output int stalls,
                          output logic fb, output logic lb);
    int n, k, stall_left, fv;
    int bad_frame, bad_sel, bad_hold, bad_bits, bad_ready;
    bit done, early, prev_stall;
    logic psd, psl;
    logic [6:0] psel;
    n = len_of(d);
    k = 0; stall_left = 0; fv = -1; cyc = -1; stalls = 0;
    bad_frame = 0; bad_sel = 0; bad_hold = 0;
    bad_bits = 0; bad_ready = 0;
    done = 0; early = 0; prev_stall = 0;
    psd = 0; psl = 0; psel = '0; fb = 0; lb = 0;
    chk($sformatf("d%0d load_ready before accept", d), lr_w[d], 1);
    lv[d] = 1'b1; ld[d] = f; rdy[d] = 1'b1;
    @(negedge clk);
    lv[d] = 1'b0; ld[d] = '0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (c > 0 && !bz_w[d]) begin
        done = 1; cyc = c;
        if (k != n) early = 1;
      end else begin
        if (mf_w[d] !== f) bad_frame++;
        if (lr_w[d] !== 1'b0) bad_ready++;
        if (sv_w[d] && fv < 0) fv = c;
        if (prev_stall && (sd_w[d] !== psd || sl_w[d] !== psl ||
                           sel_w[d] !== psel)) bad_hold++;
        if (k + int'(sv_w[d]) < n &&
            sel_w[d] !== 7'(ord(d, k + int'(sv_w[d])))) bad_sel++;
        if (mode == 1) rdy[d] = 1'($urandom_range(0, 1));
        else if (stall_left > 0) begin
          rdy[d] = 1'b0; stall_left--;
        end else rdy[d] = 1'b1;
        lv[d] = glitch && c >= 10 && c <= 12;
        ld[d] = lv[d] ? '1 : '0;
        prev_stall = 0;
        if (sv_w[d]) begin
          if (rdy[d]) begin
            if (sd_w[d] !== f[ord(d, k)] || sl_w[d] !== (k == n - 1))
              bad_bits++;
            if (k == 0) fb = sd_w[d];
            lb = sd_w[d];
            k++;
            if (mode == 2 && k == 4) stall_left = 5;
          end else begin
            stalls++; prev_stall = 1;
            psd = sd_w[d]; psl = sl_w[d]; psel = sel_w[d];
          end
        end
        if (abort_at >= 0 && k == abort_at) done = 1;
        else @(negedge clk);
      end
    end
    lv[d] = 1'b0; ld[d] = '0;
    if (abort_at < 0) begin
      chk($sformatf("d%0d frame completes", d), done, 1);
      chk($sformatf("d%0d no early idle", d), early, 0);
      chk($sformatf("d%0d bit count", d), k, n);
      chk($sformatf("d%0d bit values", d), bad_bits, 0);
      chk($sformatf("d%0d mux_select order", d), bad_sel, 0);
      chk($sformatf("d%0d stall hold", d), bad_hold, 0);
      chk($sformatf("d%0d mux_frame stable", d), bad_frame, 0);
      chk($sformatf("d%0d load_ready low busy", d), bad_ready, 0);
      chk($sformatf("d%0d first valid cycle", d), fv, 1);
      chk($sformatf("d%0d idle outputs", d),
          {lr_w[d], sv_w[d], sl_w[d], sel_w[d]}, {1'b1, 1'b0, 1'b0, 7'd0});
    end
    rdy[d] = 1'b0;
  endtask

  typedef struct {
    int           d;
    logic [127:0] f;
    int           mode;
    logic         exp_first;
    logic         exp_last;
    int           exp_cyc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cyc, stalls, d;
    logic fb, lb;
    logic [127:0] f;

    vecs[0] = '{0, 128'h1, 0, 1'b1, 1'b0, 129};
    vecs[1] = '{1, 128'h8000_0000_0000_0000_0000_0000_0000_0001,
                0, 1'b1, 1'b1, 129};
    vecs[2] = '{0, 128'hA5, 1, 1'b1, 1'b0, 129};
    vecs[3] = '{1, 128'hA5, 1, 1'b0, 1'b1, 129};
    vecs[4] = '{2, 128'h1, 0, 1'b1, 1'b1, 2};
    vecs[5] = '{2, 128'h0, 1, 1'b0, 1'b0, 2};
    vecs[6] = '{0, {128{1'b1}}, 1, 1'b1, 1'b1, 129};
    vecs[7] = '{1, 128'h0, 0, 1'b0, 1'b0, 129};
    for (int i = 0; i < 3; i++) ld[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d reset outputs", i),
          {sv_w[i], sd_w[i], sl_w[i], bz_w[i], lr_w[i], sel_w[i]}, '0);
      chk($sformatf("d%0d reset frame", i), mf_w[i], '0);
    end
    reset = 1'b1;
    #1;
    chk("load_ready after release", lr_w, 3'b111);

    for (int i = 0; i < 8; i++) begin
      do_frame(vecs[i].d, vecs[i].f, vecs[i].mode, 1'b0, -1,
               cyc, stalls, fb, lb);
      chk($sformatf("vec%0d cycles", i), cyc - stalls, vecs[i].exp_cyc);
      chk($sformatf("vec%0d first bit", i), fb, vecs[i].exp_first);
      chk($sformatf("vec%0d last bit", i), lb, vecs[i].exp_last);
    end

    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(0, 2);
      f = {$urandom, $urandom, $urandom, $urandom};
      do_frame(d, f, 1, 1'b0, -1, cyc, stalls, fb, lb);
      chk($sformatf("rnd%0d cycles", i), cyc - stalls, len_of(d) + 1);
      chk($sformatf("rnd%0d first bit", i), fb, f[ord(d, 0)]);
      chk($sformatf("rnd%0d last bit", i), lb, f[ord(d, len_of(d) - 1)]);
    end

    f = {$urandom, $urandom, $urandom, $urandom};
    do_frame(0, f, 2, 1'b0, -1, cyc, stalls, fb, lb);
    chk("stall total cycles", cyc, 134);
    chk("stall count", stalls, 5);

    do_frame(0, 128'h5A5A_0F0F_3C3C_9696_5A5A_0F0F_3C3C_9696, 0, 1'b1, -1,
             cyc, stalls, fb, lb);
    chk("glitch cycles", cyc, 129);

    f = {$urandom, $urandom, $urandom, $urandom};
    do_frame(0, f, 0, 1'b0, 60, cyc, stalls, fb, lb);
    #2 reset = 1'b0;
    #1;
    chk("async reset outputs",
        {sv_w[0], sd_w[0], sl_w[0], bz_w[0], lr_w[0], sel_w[0]}, '0);
    chk("async reset frame", mf_w[0], '0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("load_ready same cycle", lr_w[0], 1);
    do_frame(0, 128'hA5, 0, 1'b0, -1, cyc, stalls, fb, lb);
    chk("post reset cycles", cyc, 129);
    chk("post reset first bit", fb, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
